uart_rx_sram_wrapper: RTL

Memory-mapped UART receiver; counterpart of the UART transmit wrapper on the same CPU data-SRAM port. It deserialises 8N1 frames from `uart_rx_pin` and buffers received bytes in a small FIFO. The CPU reads those bytes, plus a status word, through the `data_sram_*` bus with one-cycle read latency. It sits beside the TX wrapper in the peripheral address decode, selected by the same `data_sram_en` qualification.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_core.sv | 111 +++++++++++
 rtl/uart_rx_sram_wrapper.sv | 123 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: register offsets, status bit positions and receiver states.
// The TX wrapper uses the same offsets, so keep them here.
package uart_pkg;

    localparam logic [11:0] UART_DATA_OFS   = 12'h000;
    localparam logic [11:0] UART_STATUS_OFS = 12'h004;

    localparam int STAT_VALID_BIT     = 0;
    localparam int STAT_OVERRUN_BIT   = 1;
    localparam int STAT_FRAME_ERR_BIT = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: pin synchroniser, down-counting baud timer and frame state machine.
// Emits a received byte with a one-cycle push pulse, or a one-cycle frame-error pulse.
//
// state        | meaning
// RX_IDLE      | line idle, waiting for a synchronised low
// RX_START     | half a bit period into the start bit, glitch check
// RX_DATA      | sampling 8 data bits LSB first, one bit period apart
// RX_STOP      | sampling the stop bit
// RX_WAIT_HIGH | bad stop bit seen, waiting for the line to return high
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_pin,
    output logic [7:0] rx_byte,
    output logic       rx_push,
    output logic       rx_frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CPB_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

    rx_state_e        state_q, state_d;
    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             push_q, push_d;
    logic             ferr_q, ferr_d;
    logic             rx_s;
    logic             tick;

    assign rx_s = sync2_q;
    assign tick = (baud_cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RX_IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            push_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= rx_pin;
            sync2_q    <= sync1_q;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            push_q     <= push_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE:      if (!rx_s) state_d = RX_START;
            RX_START:     if (tick) state_d = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:      if (tick && bit_cnt_q == 3'd7) state_d = RX_STOP;
            RX_STOP:      if (tick) state_d = rx_s ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (rx_s) state_d = RX_IDLE;
            default:      state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        push_d = (state_q == RX_STOP) && tick && rx_s;
        ferr_d = (state_q == RX_STOP) && tick && !rx_s;
    end

    // Baud timer reloads to a full bit period on every sample point.
    always_comb begin
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        case (state_q)
            RX_IDLE: begin
                baud_cnt_d = HALF_M1;
                bit_cnt_d  = '0;
            end
            RX_START, RX_STOP: begin
                baud_cnt_d = tick ? CPB_M1 : baud_cnt_q - 1'b1;
            end
            RX_DATA: begin
                if (tick) begin
                    baud_cnt_d = CPB_M1;
                    shift_d    = {rx_s, shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            default: begin
                baud_cnt_d = '0;
            end
        endcase
    end

    assign rx_byte      = shift_q;
    assign rx_push      = push_q;
    assign rx_frame_err = ferr_q;

endmodule

// File: rtl/uart_rx_sram_wrapper.sv
// Memory-mapped UART receiver on the CPU data-SRAM port: RX FIFO, sticky error
// flags and a registered read path with one-cycle latency.
module uart_rx_sram_wrapper
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic        uart_rx_pin
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNT_W        = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [7:0]       rx_byte;
    logic             rx_push;
    logic             rx_frame_err;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [11:0]      addr_lo;
    logic             rd_req;
    logic             clr_sel;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push;
    logic             overrun_set;
    logic             unused_bits;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_core (
        .clk          (clk),
        .rst          (rst),
        .rx_pin       (uart_rx_pin),
        .rx_byte      (rx_byte),
        .rx_push      (rx_push),
        .rx_frame_err (rx_frame_err)
    );

    assign addr_lo     = data_sram_addr[11:0];
    assign unused_bits = ^{data_sram_addr[31:12], data_sram_wdata[31:3], data_sram_wdata[0]};

    assign rd_req     = data_sram_en && (data_sram_wen == 4'b0000);
    assign clr_sel    = data_sram_en && (|data_sram_wen) && (addr_lo == UART_STATUS_OFS);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign pop         = rd_req && (addr_lo == UART_DATA_OFS) && !fifo_empty;
    assign push        = rx_push && (!fifo_full || pop);
    assign overrun_set = rx_push && fifo_full && !pop;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        overrun_d   = overrun_set
                    | (overrun_q & ~(clr_sel & data_sram_wdata[STAT_OVERRUN_BIT]));
        frame_err_d = rx_frame_err
                    | (frame_err_q & ~(clr_sel & data_sram_wdata[STAT_FRAME_ERR_BIT]));
    end

    always_comb begin
        rdata_d = '0;
        if (rd_req) begin
            if (addr_lo == UART_DATA_OFS) begin
                if (!fifo_empty) rdata_d = {24'b0, mem_q[rd_ptr_q]};
            end else if (addr_lo == UART_STATUS_OFS) begin
                rdata_d[STAT_VALID_BIT]     = !fifo_empty;
                rdata_d[STAT_OVERRUN_BIT]   = overrun_q;
                rdata_d[STAT_FRAME_ERR_BIT] = frame_err_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            rdata_q     <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rx_byte;
    end

    assign data_sram_rdata = rdata_q;

endmodule
